// File: rtl/alu_issue_stage.sv
// alu_issue_stage: multi-cycle issue stage in front of the combinational ALU.
// It accepts one instruction per handshake, reads the operands from an
// internal 32x32 register file and presents them to the ALU. After
// EXEC_CYCLES cycles it samples the ALU result and branch flag, then
// writes the result back to the register file.
module alu_issue_stage #(
  parameter int EXEC_CYCLES = 1  // ALU settle time in cycles, 1..15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] rs_content,
  output logic [31:0] rt_content,
  output logic [4:0]  shamt,
  output logic [5:0]  ALU_control,
  output logic [15:0] immediate,
  input  logic [31:0] ALU_result,
  input  logic        sig_branch,
  output logic        wb_valid,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        branch_taken,
  output logic        done,
  input  logic        dbg_we,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

  state_t      state, state_next;
  logic [31:0] instr_q;
  logic [3:0]  exec_cnt;
  logic [31:0] regfile [32];
  logic        is_rtype, is_branch;
  logic [4:0]  dest;

  // Decode the captured word: destination register and instruction class.
  always_comb begin
    is_rtype  = (instr_q[31:26] == OP_RTYPE);
    is_branch = (instr_q[31:26] == OP_BEQ) || (instr_q[31:26] == OP_BNE);
    dest      = is_rtype ? instr_q[15:11] : instr_q[20:16];
  end

  // Handshake and write-back strobes follow the state directly.
  always_comb begin
    instr_ready = rst_n && (state == IDLE);
    done        = (state == WB);
    wb_valid    = (state == WB) && !is_branch && (dest != 5'd0);
    wb_addr     = dest;
    dbg_rdata   = regfile[dbg_addr];
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: every clocked block uses <= so all registers see pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      IDLE:    if (instr_valid) state_next = DECODE;
      DECODE:  state_next = EXEC;
      EXEC:    if (exec_cnt == 4'd0) state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture the instruction, drive the ALU operands, count the settle time, sample the results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q      <= '0;
      exec_cnt     <= '0;
      opcode       <= '0;
      rs_content   <= '0;
      rt_content   <= '0;
      shamt        <= '0;
      ALU_control  <= '0;
      immediate    <= '0;
      wb_data      <= '0;
      branch_taken <= 1'b0;
    end else begin
      case (state)
        IDLE: if (instr_valid) instr_q <= instr;
        DECODE: begin
          opcode      <= instr_q[31:26];
          rs_content  <= regfile[instr_q[25:21]];
          rt_content  <= regfile[instr_q[20:16]];
          shamt       <= instr_q[10:6];
          immediate   <= instr_q[15:0];
          ALU_control <= is_rtype ? instr_q[5:0] : 6'd0;
          exec_cnt    <= EXEC_LOAD;
        end
        EXEC: begin
          if (exec_cnt == 4'd0) begin
            wb_data      <= ALU_result;
            branch_taken <= is_branch && sig_branch;
          end else begin
            exec_cnt <= exec_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Register file: debug preload in IDLE, result write-back on leaving WB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: this memory is cleared on reset because reset is defined to zero all registers; leave it unreset where that is not required.
      for (int i = 0; i < 32; i++) regfile[i] <= '0;
    end else if (wb_valid) begin
      regfile[dest] <= wb_data;
    end else if ((state == IDLE) && dbg_we && (dbg_addr != 5'd0)) begin
      regfile[dbg_addr] <= dbg_wdata;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage. Instance dut runs with
// EXEC_CYCLES=1 and instance dut_b with EXEC_CYCLES=3. A small reference
// ALU model drives each instance's ALU_result and sig_branch inputs.
module tb_alu_issue_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A signals (EXEC_CYCLES = 1)
  logic        instr_valid, instr_ready, sig_branch, wb_valid, branch_taken, done, dbg_we;
  logic [31:0] instr, rs_content, rt_content, ALU_result, wb_data, dbg_wdata, dbg_rdata;
  logic [5:0]  opcode, ALU_control;
  logic [4:0]  shamt, wb_addr, dbg_addr;
  logic [15:0] immediate;

  // Instance B signals (EXEC_CYCLES = 3)
  logic        instr_valid_b, instr_ready_b, sig_branch_b, wb_valid_b, branch_taken_b, done_b, dbg_we_b;
  logic [31:0] instr_b, rs_content_b, rt_content_b, ALU_result_b, wb_data_b, dbg_wdata_b, dbg_rdata_b;
  logic [5:0]  opcode_b, ALU_control_b;
  logic [4:0]  shamt_b, wb_addr_b, dbg_addr_b;
  logic [15:0] immediate_b;

  alu_issue_stage #(.EXEC_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .opcode(opcode), .rs_content(rs_content), .rt_content(rt_content),
    .shamt(shamt), .ALU_control(ALU_control), .immediate(immediate),
    .ALU_result(ALU_result), .sig_branch(sig_branch), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .wb_data(wb_data), .branch_taken(branch_taken), .done(done),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata)
  );

  alu_issue_stage #(.EXEC_CYCLES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid_b), .instr_ready(instr_ready_b),
    .instr(instr_b), .opcode(opcode_b), .rs_content(rs_content_b), .rt_content(rt_content_b),
    .shamt(shamt_b), .ALU_control(ALU_control_b), .immediate(immediate_b),
    .ALU_result(ALU_result_b), .sig_branch(sig_branch_b), .wb_valid(wb_valid_b),
    .wb_addr(wb_addr_b), .wb_data(wb_data_b), .branch_taken(branch_taken_b), .done(done_b),
    .dbg_we(dbg_we_b), .dbg_addr(dbg_addr_b), .dbg_wdata(dbg_wdata_b), .dbg_rdata(dbg_rdata_b)
  );

  // Reference ALU covering the few operations the vectors use: {branch, result}.
  function automatic logic [32:0] alu_model(input logic [5:0] op, input logic [31:0] rs,
                                            input logic [31:0] rt, input logic [5:0] ctrl,
                                            input logic [15:0] imm);
    logic [32:0] r;
    r = '0;
    case (op)
      6'b000000: r[31:0] = (ctrl == 6'b100110) ? (rs ^ rt) : (rs + rt);
      6'b001110: r[31:0] = rs ^ {16'd0, imm};
      6'b000100: begin r[31:0] = rs - rt; r[32] = (rs == rt); end
      6'b000101: begin r[31:0] = rs - rt; r[32] = (rs != rt); end
      default:   r = '0;
    endcase
    return r;
  endfunction

  always_comb {sig_branch, ALU_result} = alu_model(opcode, rs_content, rt_content, ALU_control, immediate);
  always_comb {sig_branch_b, ALU_result_b} = alu_model(opcode_b, rs_content_b, rt_content_b, ALU_control_b, immediate_b);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    dbg_addr = addr;
    #1;
    check(tag, dbg_rdata, exp);
  endtask

  task automatic preload(input logic [4:0] addr, input logic [31:0] data);
    dbg_we = 1'b1; dbg_addr = addr; dbg_wdata = data;
    tick();
    dbg_we = 1'b0;
  endtask

  // Offer one instruction; return in the DECODE cycle after the accept edge.
  task automatic issue(input logic [31:0] w);
    instr = w; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
  endtask

  logic [31:0] w1, w2;
  int acc[$];
  int dones;

  initial begin
    rst_n = 1'b0;
    instr_valid = 1'b0; instr = '0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    instr_valid_b = 1'b0; instr_b = '0; dbg_we_b = 1'b0; dbg_addr_b = '0; dbg_wdata_b = '0;

    // Reset state
    tick();
    check("ready_in_reset", instr_ready, 0);
    check("done_in_reset", done, 0);
    check("opcode_in_reset", opcode, 0);
    rst_n = 1'b1;
    tick();
    check("ready_after_reset", instr_ready, 1);

    // Reset asserted in the middle of EXEC of an XORI aborts it
    issue({6'b001110, 5'd1, 5'd2, 16'd19});
    tick();                       // now in EXEC
    rst_n = 1'b0;
    tick();
    check("abort_done", done, 0);
    check("abort_wb_valid", wb_valid, 0);
    check("abort_ready_low", instr_ready, 0);
    rst_n = 1'b1;
    tick();
    check("abort_ready_high", instr_ready, 1);
    check("abort_no_done", done, 0);
    peek("abort_r2", 5'd2, 0);

    // XORI: r1=20, imm=19 -> r2=7
    preload(5'd1, 32'd20);
    peek("preload_r1", 5'd1, 20);
    issue({6'b001110, 5'd1, 5'd2, 16'd19});
    check("xori_ready_decode", instr_ready, 0);
    tick();                       // accept+1: EXEC, operands valid
    check("xori_rs", rs_content, 20);
    check("xori_imm", {16'd0, immediate}, 19);
    check("xori_opcode", {26'd0, opcode}, 6'b001110);
    check("xori_ctrl", {26'd0, ALU_control}, 0);
    check("xori_no_done_exec", done, 0);
    tick();                       // accept+2: WB
    check("xori_done", done, 1);
    check("xori_wb_valid", wb_valid, 1);
    check("xori_wb_addr", {27'd0, wb_addr}, 2);
    check("xori_wb_data", wb_data, 7);
    peek("xori_r2_old", 5'd2, 0);
    tick();
    check("xori_done_clear", done, 0);
    check("xori_ready_back", instr_ready, 1);
    peek("xori_r2_new", 5'd2, 7);

    // R-type xor: r3=33, r4=2 -> r5=35
    preload(5'd3, 32'd33);
    preload(5'd4, 32'd2);
    issue({6'd0, 5'd3, 5'd4, 5'd5, 5'd0, 6'b100110});
    tick();
    check("rtype_ctrl", {26'd0, ALU_control}, 6'b100110);
    check("rtype_rs", rs_content, 33);
    check("rtype_rt", rt_content, 2);
    tick();
    check("rtype_wb_addr", {27'd0, wb_addr}, 5);
    check("rtype_wb_valid", wb_valid, 1);
    check("rtype_wb_data", wb_data, 35);
    check("rtype_branch", branch_taken, 0);
    tick();
    peek("rtype_r5", 5'd5, 35);

    // Branch BEQ r3,r3 -> taken, no write
    issue({6'b000100, 5'd3, 5'd3, 16'd4});
    tick();
    tick();
    check("beq_done", done, 1);
    check("beq_wb_valid", wb_valid, 0);
    check("beq_taken", branch_taken, 1);
    tick();
    check("beq_taken_hold", branch_taken, 1);
    peek("beq_r3", 5'd3, 33);

    // XORI into r0: suppressed write, branch_taken cleared
    issue({6'b001110, 5'd0, 5'd0, 16'd8});
    tick();
    tick();
    check("r0_done", done, 1);
    check("r0_wb_valid", wb_valid, 0);
    check("r0_branch_clr", branch_taken, 0);
    tick();
    peek("r0_read", 5'd0, 0);

    // Back-to-back on dut_b (EXEC_CYCLES=3) with instr_valid held high
    w1 = {6'b001110, 5'd0, 5'd7, 16'd5};   // r7 = 0 ^ 5 = 5
    w2 = {6'b001110, 5'd7, 5'd8, 16'd3};   // r8 = 5 ^ 3 = 6
    instr_b = w1; instr_valid_b = 1'b1; dones = 0;
    for (int c = 0; c < 20; c++) begin
      if (instr_ready_b && instr_valid_b) acc.push_back(c);
      if (c == 3) begin dbg_we_b = 1'b1; dbg_addr_b = 5'd6; dbg_wdata_b = 32'd99; end
      else dbg_we_b = 1'b0;
      tick();
      if (done_b) dones++;
      if (acc.size() == 1) instr_b = w2;
      if (acc.size() >= 2) instr_valid_b = 1'b0;
    end
    check("b2b_accepts", acc.size(), 2);
    if (acc.size() == 2) check("b2b_spacing", acc[1] - acc[0], 6);
    check("b2b_dones", dones, 2);
    dbg_addr_b = 5'd6; #1; check("b2b_dbg_ignored", dbg_rdata_b, 0);
    dbg_addr_b = 5'd7; #1; check("b2b_r7", dbg_rdata_b, 5);
    dbg_addr_b = 5'd8; #1; check("b2b_r8", dbg_rdata_b, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
